// File: rtl/axi_slave_mem.sv
// AXI3 slave backed by an internal word memory.
// Independent write and read channels, one burst in flight per channel.
module axi_slave_mem #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(DEPTH * 4);

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  logic [31:0] mem [DEPTH];

  function automatic logic in_range(input logic [31:0] a);
    return (a - BASE_ADDR) < SPAN;
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    return AW'((a - BASE_ADDR) >> 2);
  endfunction

  function automatic logic wrap_len_ok(input logic [3:0] len);
    return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
  endfunction

  function automatic logic burst_err(input logic [2:0] size, input logic [1:0] burst,
                                     input logic [3:0] len);
    return (size > 3'd2) || ((burst == BURST_WRAP) && !wrap_len_ok(len));
  endfunction

  // An illegal WRAP length falls back to INCR addressing.
  function automatic logic [1:0] eff_burst(input logic [1:0] burst, input logic [3:0] len);
    return ((burst == BURST_WRAP) && !wrap_len_ok(len)) ? BURST_INCR : burst;
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [3:0] len,
                                            input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] step;
    logic [31:0] mask;
    step = 32'd1 << size;
    mask = (({28'd0, len} + 32'd1) << size) - 32'd1;
    case (burst)
      BURST_FIXED: return a;
      BURST_WRAP:  return (a & ~mask) | ((a + step) & mask);
      default:     return a + step;
    endcase
  endfunction

  // ---------------- write channel ----------------
  w_state_t    w_state, w_state_nx;
  logic [3:0]  aw_id_q, aw_len_q, w_cnt;
  logic [2:0]  aw_size_q;
  logic [1:0]  aw_burst_q;
  logic [31:0] w_addr;
  logic        w_err;
  logic        w_beat, w_beat_err, w_final;

  assign w_beat     = (w_state == W_DATA) && wvalid;
  assign w_final    = (w_cnt == aw_len_q);
  assign w_beat_err = !in_range(w_addr) || (wid != aw_id_q) || (wlast != w_final);
  assign bid        = aw_id_q;
  assign bresp      = w_err ? RESP_SLVERR : RESP_OKAY;

  // Write FSM state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) w_state <= W_IDLE;
    else          w_state <= w_state_nx;
  end

  // Write FSM next state and handshake outputs; beat count alone ends the burst.
  always_comb begin
    w_state_nx = w_state;
    awready    = 1'b0;
    wready     = 1'b0;
    bvalid     = 1'b0;
    case (w_state)
      W_IDLE: begin
        awready = 1'b1;
        if (awvalid) w_state_nx = W_DATA;
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid && w_final) w_state_nx = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) w_state_nx = W_IDLE;
      end
      default: w_state_nx = W_IDLE;
    endcase
  end

  // Write burst context: captured on AW, advanced per W beat, errors accumulated.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_id_q    <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
      aw_burst_q <= '0;
      w_addr     <= '0;
      w_cnt      <= '0;
      w_err      <= 1'b0;
    end else if ((w_state == W_IDLE) && awvalid) begin
      aw_id_q    <= awid;
      aw_len_q   <= awlen;
      aw_size_q  <= awsize;
      aw_burst_q <= eff_burst(awburst, awlen);
      w_addr     <= awaddr;
      w_cnt      <= '0;
      w_err      <= burst_err(awsize, awburst, awlen);
    end else if (w_beat) begin
      w_addr <= next_addr(w_addr, aw_len_q, aw_size_q, aw_burst_q);
      w_cnt  <= w_cnt + 4'd1;
      w_err  <= w_err | w_beat_err;
    end
  end

  // Byte-lane memory write; out-of-range beats are dropped.
  always_ff @(posedge aclk) begin
    if (w_beat && in_range(w_addr)) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[word_idx(w_addr)][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  r_state_t    r_state, r_state_nx;
  logic [3:0]  ar_len_q, r_cnt;
  logic [2:0]  ar_size_q;
  logic [1:0]  ar_burst_q;
  logic [31:0] r_addr, r_next, r_fetch;
  logic        r_err, r_fetch_err, ar_hs, r_hs;

  assign ar_hs       = (r_state == R_IDLE) && arvalid;
  assign r_hs        = (r_state == R_DATA) && rready;
  assign r_next      = next_addr(r_addr, ar_len_q, ar_size_q, ar_burst_q);
  assign r_fetch     = ar_hs ? araddr : r_next;
  assign r_fetch_err = ar_hs ? burst_err(arsize, arburst, arlen) : r_err;

  // Read FSM state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= R_IDLE;
    else          r_state <= r_state_nx;
  end

  // Read FSM next state and handshake outputs.
  always_comb begin
    r_state_nx = r_state;
    arready    = 1'b0;
    rvalid     = 1'b0;
    case (r_state)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) r_state_nx = R_DATA;
      end
      R_DATA: begin
        rvalid = 1'b1;
        if (rready && (r_cnt == ar_len_q)) r_state_nx = R_IDLE;
      end
      default: r_state_nx = R_IDLE;
    endcase
  end

  // Read datapath: rdata is prefetched for the beat about to be presented, so a
  // pre-write word is returned when a write to the same word lands in that cycle.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rid        <= '0;
      rdata      <= '0;
      rresp      <= '0;
      rlast      <= 1'b0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
    end else if (ar_hs || (r_hs && (r_cnt != ar_len_q))) begin
      rdata <= in_range(r_fetch) ? mem[word_idx(r_fetch)] : '0;
      rresp <= (r_fetch_err || !in_range(r_fetch)) ? RESP_SLVERR : RESP_OKAY;
      if (ar_hs) begin
        rid        <= arid;
        ar_len_q   <= arlen;
        ar_size_q  <= arsize;
        ar_burst_q <= eff_burst(arburst, arlen);
        r_addr     <= araddr;
        r_cnt      <= '0;
        r_err      <= burst_err(arsize, arburst, arlen);
        rlast      <= (arlen == 4'd0);
      end else begin
        r_addr <= r_next;
        r_cnt  <= r_cnt + 4'd1;
        rlast  <= ((r_cnt + 4'd1) == ar_len_q);
      end
    end else if (r_hs) begin
      rlast <= 1'b0;
    end
  end

endmodule

// File: doc/axi_slave_mem.md
Name: axi_slave_mem

Overview:
- Synthesizable AXI3 slave responder: the RTL far end of the AXI bus driven by the team's master VIP.
- Backs all transactions with an internal word memory.
- Accepts one write burst and one read burst at a time on independent channels.
- Serves as the DUT and reference target for master-side VIP tests and scoreboard checks.

Parameters:
- DEPTH, 1024, number of 32-bit memory words (power of two).
- BASE_ADDR, 32'h0000_0000, byte address of word 0. Must be aligned to DEPTH*4.

Ports:
- aclk  in  1  bus clock; all logic on rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- awid  in  4  write address ID.
- awaddr  in  32  write start byte address.
- awlen  in  4  write beats minus 1.
- awsize  in  3  bytes per beat, log2.
- awburst  in  2  write burst type: 0 FIXED, 1 INCR, 2 WRAP.
- awvalid  in  1  write address valid.
- awready  out  1  write address ready.
- wid  in  4  write data ID.
- wdata  in  32  write data.
- wstrb  in  4  byte-lane strobes.
- wlast  in  1  last write beat.
- wvalid  in  1  write data valid.
- wready  out  1  write data ready.
- bid  out  4  response ID.
- bresp  out  2  write response: 0 OKAY, 2 SLVERR.
- bvalid  out  1  write response valid.
- bready  in  1  write response ready.
- arid  in  4  read address ID.
- araddr  in  32  read start byte address.
- arlen  in  4  read beats minus 1.
- arsize  in  3  bytes per beat, log2.
- arburst  in  2  read burst type.
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- rid  out  4  read ID.
- rdata  out  32  read data.
- rresp  out  2  read response.
- rlast  out  1  last read beat.
- rvalid  out  1  read data valid.
- rready  in  1  read data ready.

Behaviour:
- Clock and reset: one clock, aclk. aresetn is asynchronous and active-low. Asserting it mid-burst aborts both FSMs to IDLE immediately and discards the burst.
- Reset values: awready=1, arready=1. wready, bvalid, rvalid, rlast = 0. bid, bresp, rid, rresp, rdata = 0. Memory array is not reset.
- Write FSM:
  - W_IDLE: awready=1. On awvalid&awready, capture id/addr/len/size/burst, set beat count to 0, clear error flag, go to W_DATA.
  - W_DATA: awready=0, wready=1. Each wvalid&wready beat:
    - writes the byte lanes with wstrb=1 to word (addr-BASE_ADDR)>>2 if the address is in range;
    - advances the address and increments the count.
  - W_DATA exit: on the beat where count==len, go to W_RESP. This beat count is authoritative; wlast does not end the burst.
  - W_RESP: wready=0, bvalid=1, bid=captured awid. Hold until bready, then go to W_IDLE.
  - The earliest next AW accept is the cycle after the B handshake.
- Read FSM:
  - R_IDLE: arready=1. On handshake, capture fields and go to R_DATA.
  - First beat: rdata is registered from memory at the start address, so rvalid=1 exactly one cycle after the AR handshake.
  - R_DATA: each rvalid&rready beat loads the next beat's data into rdata. rvalid stays 1 and rdata stays stable while rready=0.
  - rlast=1 only on beat len. The handshake on beat len returns to R_IDLE with rvalid=0. rid=captured arid on every beat.
- Address update, per beat, with step = 1<<size:
  - FIXED: unchanged.
  - INCR: addr+step, 32-bit wrap.
  - WRAP: boundary = (len+1)*step. New address = (addr & ~(boundary-1)) | ((addr+step) & (boundary-1)).
- Narrow beats (size<2): the same memory word is addressed. Writes take lanes from wstrb as given. Reads return the full word.
- Errors. Each of the following sets SLVERR:
  - a beat address outside [BASE_ADDR, BASE_ADDR+DEPTH*4): write suppressed for that beat;
  - size>2;
  - WRAP with len not in {1,3,7,15}: that burst is then addressed as INCR;
  - on writes only, a wid mismatch with awid on any beat, or wlast value != (count==len) on any beat.
- Error reporting:
  - bresp is SLVERR if any beat of the burst errored.
  - rresp is per beat: SLVERR for an out-of-range beat or a burst-level error, else OKAY. rdata=0 on out-of-range beats.
- Simultaneous read and write to the same word in the same cycle: the read returns the old data.
- The write and read channels are fully independent.

Test Plan:
- Single write then read: AW id=3, addr=0x10, len=0, size=2, INCR; W 0xDEADBEEF, strb=F. Required: bresp=0, bid=3. AR id=5, addr=0x10 gives rdata=0xDEADBEEF, rid=5, rlast=1, rvalid one cycle after AR.
- INCR burst with backpressure: write len=3 at 0x100 with data 1..4. Read back with rready toggled 1,0,1,0. Required: 4 beats 1,2,3,4, data stable during stalls, rlast only on beat 4.
- WRAP: read len=3, size=2, addr=0x38 over words preloaded 0x30..0x3C. Required: addresses 0x38, 0x3C, 0x30, 0x34; all rresp=0.
- Strobes: write 0xFFFFFFFF, then 0x00000000 with strb=4'b0101. Required: read returns 0xFF00FF00.
- Errors:
  - write at BASE_ADDR+DEPTH*4 → bresp=2, memory unchanged;
  - write len=1 with wlast on beat 0 → bresp=2;
  - read arsize=3 → all rresp=2.
- Reset mid-burst: deassert aresetn during beat 2 of a len=7 read. Required: rvalid=0 immediately, arready=1 after release, and the next read completes correctly.
